// File: rtl/iir_pkg.sv
// iir_pkg: shared constants for the biquad IIR sequencer slice.
//   - Default sample/coefficient width, fractional bits and accumulator width.
//   - Coefficient-mux select codes, matching the external coefficient mux.
//   - FSM state encoding, plus a helper that maps a MAC step to its coefficient select.
package iir_pkg;

  localparam int W_DEF     = 25;
  localparam int FRAC_DEF  = 19;
  localparam int ACC_W_DEF = 56;

  localparam logic [2:0] SEL_A1 = 3'd0;
  localparam logic [2:0] SEL_A2 = 3'd1;
  localparam logic [2:0] SEL_B0 = 3'd2;
  localparam logic [2:0] SEL_B1 = 3'd3;
  localparam logic [2:0] SEL_B2 = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [2:0] LAST_STEP = 3'd4;

  // MAC step order is b0,b1,b2,a1,a2 (feed-forward terms first).
  function automatic logic [2:0] step_sel(input logic [2:0] step);
    logic [2:0] sel;
    case (step)
      3'd0:    sel = SEL_B0;
      3'd1:    sel = SEL_B1;
      3'd2:    sel = SEL_B2;
      3'd3:    sel = SEL_A1;
      3'd4:    sel = SEL_A2;
      default: sel = SEL_B0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/iir_mac.sv
// iir_mac: single multiplier + accumulator + round/format stage for the biquad.
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset, clears the accumulator
//   clear    in   clears the accumulator (start of a new sample)
//   en       in   adds coef*operand (full 2W-bit product, sign-extended) to the accumulator
//   coef     in   W-bit signed coefficient
//   operand  in   W-bit signed sample/history operand
//   fmt_out  out  rounded (half up) and formatted result of the current accumulator
// Build option: IIR_SAT_EN defined -> fmt_out saturates to the W-bit signed range;
//               undefined -> fmt_out is the low W bits of the rounded value (wrap).
import iir_pkg::*;

module iir_mac #(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic signed [W-1:0] coef,
  input  logic signed [W-1:0] operand,
  output logic signed [W-1:0] fmt_out
);

  localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC-1);

  logic signed [2*W-1:0]   prod_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] rnd_s;
  logic signed [ACC_W-1:0] r_s;
  logic signed [W-1:0]     fmt_s;

  assign prod_s = coef * operand;
  assign rnd_s  = acc_r + HALF;
  assign r_s    = rnd_s >>> FRAC;

  // Accumulator: cleared at sample accept, one product added per MAC step.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + {{(ACC_W-2*W){prod_s[2*W-1]}}, prod_s};
    end else begin
      acc_r <= acc_r;
    end
  end

`ifdef IIR_SAT_EN
  // Saturate when the bits above the W-bit sign position disagree.
  always_comb begin
    if ((&r_s[ACC_W-1:W-1]) || (~|r_s[ACC_W-1:W-1])) begin
      fmt_s = r_s[W-1:0];
    end else if (r_s[ACC_W-1]) begin
      fmt_s = {1'b1, {(W-1){1'b0}}};
    end else begin
      fmt_s = {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  logic unused_hi_s;
  assign unused_hi_s = ^r_s[ACC_W-1:W];

  // Plain two's-complement wrap to W bits.
  always_comb begin
    fmt_s = r_s[W-1:0];
  end
`endif

  assign fmt_out = fmt_s;

endmodule

// File: rtl/iir_biquad_sequencer.sv
// iir_biquad_sequencer: direct-form-I biquad, one multiplier time-shared over 5 steps.
//   y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] + a2*y[n-2]  (a1/a2 arrive pre-signed)
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   x_valid   in   one-cycle strobe, x_in holds a new sample
//   x_in      in   W-bit signed input sample
//   coef_sel  out  coefficient index to the external mux (000=a1 001=a2 010=b0 011=b1 100=b2)
//   coef_in   in   W-bit signed coefficient returned combinationally by the mux
//   y_out     out  filtered sample, held until the next result
//   y_valid   out  one-cycle pulse when y_out updates
//   busy      out  high while a sample is being processed (MAC and OUT states)
//   overrun   out  sticky flag: a sample arrived while busy (cleared only by reset)
// Build option: IIR_SAT_EN selects saturating output formatting (see iir_mac).
import iir_pkg::*;

module iir_biquad_sequencer #(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         x_valid,
  input  logic [W-1:0] x_in,
  output logic [2:0]   coef_sel,
  input  logic [W-1:0] coef_in,
  output logic [W-1:0] y_out,
  output logic         y_valid,
  output logic         busy,
  output logic         overrun
);

  logic [1:0]   state_r;
  logic [2:0]   step_r;
  logic [W-1:0] x0_r;
  logic [W-1:0] x1_r;
  logic [W-1:0] x2_r;
  logic [W-1:0] y1_r;
  logic [W-1:0] y2_r;
  logic [W-1:0] operand_s;
  logic [W-1:0] fmt_s;
  logic         mac_clear_s;
  logic         mac_en_s;

  assign mac_clear_s = (state_r == ST_IDLE) && x_valid;
  assign mac_en_s    = (state_r == ST_MAC);

  // Operand paired with the coefficient currently selected by step_r.
  always_comb begin
    case (step_r)
      3'd0:    operand_s = x0_r;
      3'd1:    operand_s = x1_r;
      3'd2:    operand_s = x2_r;
      3'd3:    operand_s = y1_r;
      3'd4:    operand_s = y2_r;
      default: operand_s = '0;
    endcase
  end

  iir_mac #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear   (mac_clear_s),
    .en      (mac_en_s),
    .coef    (coef_in),
    .operand (operand_s),
    .fmt_out (fmt_s)
  );

  // Control FSM, delay line and output registers.
  // coef_sel is registered one step ahead so the mux output is settled
  // for the whole MAC step; it rests on b0 outside MAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      step_r   <= 3'd0;
      x0_r     <= '0;
      x1_r     <= '0;
      x2_r     <= '0;
      y1_r     <= '0;
      y2_r     <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      coef_sel <= SEL_B0;
    end else begin
      y_valid <= 1'b0;
      if (x_valid && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
      case (state_r)
        ST_IDLE: begin
          if (x_valid) begin
            x0_r     <= x_in;
            step_r   <= 3'd0;
            busy     <= 1'b1;
            coef_sel <= SEL_B0;
            state_r  <= ST_MAC;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_MAC: begin
          if (step_r == LAST_STEP) begin
            step_r   <= 3'd0;
            coef_sel <= SEL_B0;
            state_r  <= ST_OUT;
          end else begin
            step_r   <= step_r + 3'd1;
            coef_sel <= step_sel(step_r + 3'd1);
            state_r  <= ST_MAC;
          end
        end
        ST_OUT: begin
          y_out   <= fmt_s;
          y_valid <= 1'b1;
          x2_r    <= x1_r;
          x1_r    <= x0_r;
          y2_r    <= y1_r;
          y1_r    <= fmt_s;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          step_r   <= 3'd0;
          busy     <= 1'b0;
          coef_sel <= SEL_B0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// tb_iir_biquad_sequencer: directed self-checking bench for iir_biquad_sequencer.
// Includes a behavioural model of the coefficient mux (with an override used
// to force extreme coefficients) and an integer reference of the difference equation.
module tb_iir_biquad_sequencer;

  localparam logic signed [24:0] C_A1 = 25'sd1027604;
  localparam logic signed [24:0] C_A2 = -25'sd503575;
  localparam logic signed [24:0] C_B0 = 25'sd3;
  localparam logic signed [24:0] C_B1 = 25'sd7;
  localparam logic signed [24:0] C_B2 = 25'sd3;
  localparam logic [24:0]        ONE  = 25'h0080000;
  localparam logic [24:0]        BIG  = 25'h0FFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        x_valid = 1'b0;
  logic [24:0] x_in = 25'd0;
  logic [2:0]  coef_sel;
  logic [24:0] coef_in;
  logic [24:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;

  logic        ovr_en = 1'b0;
  logic [24:0] ovr_val = 25'd0;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] sel_trace [0:19];
  logic       busy_trace [0:19];

  longint m_x1, m_x2, m_y1, m_y2;

  always #5 clk = ~clk;

  iir_biquad_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .x_valid  (x_valid),
    .x_in     (x_in),
    .coef_sel (coef_sel),
    .coef_in  (coef_in),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Coefficient mux model.
  always_comb begin
    if (ovr_en) begin
      coef_in = ovr_val;
    end else begin
      case (coef_sel)
        3'd0:    coef_in = C_A1;
        3'd1:    coef_in = C_A2;
        3'd2:    coef_in = C_B0;
        3'd3:    coef_in = C_B1;
        3'd4:    coef_in = C_B2;
        default: coef_in = 25'd0;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] ref_fmt(input longint r);
`ifdef IIR_SAT_EN
    if (r > 64'sd16777215) return 25'h0FFFFFF;
    else if (r < -64'sd16777216) return 25'h1000000;
    else return r[24:0];
`else
    return r[24:0];
`endif
  endfunction

  task automatic ref_reset();
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
  endtask

  task automatic ref_sample(input logic [24:0] x, input logic use_big, output logic [24:0] y);
    longint xs, acc, r, b0, b1, b2, a1, a2;
    if (use_big) begin
      b0 = longint'($signed(BIG)); b1 = b0; b2 = b0; a1 = b0; a2 = b0;
    end else begin
      b0 = C_B0; b1 = C_B1; b2 = C_B2; a1 = C_A1; a2 = C_A2;
    end
    xs  = longint'($signed(x));
    acc = b0 * xs + b1 * m_x1 + b2 * m_x2 + a1 * m_y1 + a2 * m_y2;
    r   = (acc + 64'sd262144) >>> 19;
    y   = ref_fmt(r);
    m_x2 = m_x1; m_x1 = xs;
    m_y2 = m_y1; m_y1 = longint'($signed(y));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    x_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    ref_reset();
  endtask

  // Drive one sample and wait (bounded) for its result; lat counts cycles
  // from the x_valid cycle to the y_valid cycle.
  task automatic run_sample(input logic [24:0] x, output logic [24:0] y, output int lat);
    x_in = x;
    x_valid = 1'b1;
    lat = 0;
    do begin
      cyc();
      lat++;
      if (lat == 1) x_valid = 1'b0;
      if (lat < 20) begin
        sel_trace[lat]  = coef_sel;
        busy_trace[lat] = busy;
      end
    end while (!y_valid && lat < 20);
    y = y_out;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] y, ye, yprev;
    logic [2:0]  sel_exp [1:7];
    int          lat, pulses;
    logic [24:0] imp_exp [0:3];

    sel_exp[1] = 3'b010; sel_exp[2] = 3'b011; sel_exp[3] = 3'b100; sel_exp[4] = 3'b000;
    sel_exp[5] = 3'b001; sel_exp[6] = 3'b010; sel_exp[7] = 3'b010;
    imp_exp[0] = 25'd3; imp_exp[1] = 25'd13; imp_exp[2] = 25'd26; imp_exp[3] = 25'd38;

    // Reset state
    do_reset();
    check_eq("rst_y_out", 32'(y_out), 32'd0);
    check_eq("rst_y_valid", 32'(y_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_coef_sel", 32'(coef_sel), 32'd2);

    // Impulse response, with latency, busy and coef_sel sequence on sample 0
    for (int n = 0; n < 4; n++) begin
      run_sample((n == 0) ? ONE : 25'd0, y, lat);
      ref_sample((n == 0) ? ONE : 25'd0, 1'b0, ye);
      check_eq($sformatf("imp_y%0d", n), 32'(y), 32'(imp_exp[n]));
      check_eq($sformatf("imp_model%0d", n), 32'(y), 32'(ye));
      check_eq($sformatf("imp_lat%0d", n), 32'(lat), 32'd7);
      if (n == 0) begin
        for (int k = 1; k <= 7; k++) begin
          check_eq($sformatf("busy_c%0d", k), 32'(busy_trace[k]), (k <= 6) ? 32'd1 : 32'd0);
          check_eq($sformatf("sel_c%0d", k), 32'(sel_trace[k]), 32'(sel_exp[k]));
        end
      end
      cyc();
      check_eq($sformatf("imp_pulse%0d", n), 32'(y_valid), 32'd0);
      repeat (5) cyc();
    end
    check_eq("imp_overrun", 32'(overrun), 32'd0);

    // Overrun: second strobe 3 cycles after accept is dropped
    do_reset();
    x_in = ONE; x_valid = 1'b1;
    cyc();
    x_valid = 1'b0; x_in = BIG;
    cyc();
    cyc();
    x_valid = 1'b1;
    cyc();
    x_valid = 1'b0;
    pulses = 0;
    y = 25'd0;
    for (int k = 0; k < 16; k++) begin
      if (y_valid) begin
        pulses++;
        y = y_out;
      end
      cyc();
    end
    check_eq("ovr_pulses", 32'(pulses), 32'd1);
    check_eq("ovr_y", 32'(y), 32'd3);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    run_sample(25'd0, y, lat);
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    do_reset();
    check_eq("ovr_cleared", 32'(overrun), 32'd0);

    // Reset during MAC step 2 discards the partial result
    run_sample(ONE, y, lat);
    check_eq("mid_pre_y", 32'(y), 32'd3);
    repeat (2) cyc();
    x_in = ONE; x_valid = 1'b1;
    cyc();
    x_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ref_reset();
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_y_out", 32'(y_out), 32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (y_valid) pulses++;
      cyc();
    end
    check_eq("mid_no_pulse", 32'(pulses), 32'd0);
    run_sample(ONE, y, lat);
    check_eq("mid_reimpulse", 32'(y), 32'd3);

    // Step response, back-to-back samples every 7 cycles
    do_reset();
    yprev = 25'd0;
    for (int n = 0; n < 200; n++) begin
      run_sample(ONE, y, lat);
      ref_sample(ONE, 1'b0, ye);
      check_eq($sformatf("step_y%0d", n), 32'(y), 32'(ye));
      check_eq($sformatf("step_lat%0d", n), 32'(lat), 32'd7);
      if (n == 0) check_eq("step_first", 32'(y), 32'd3);
      else check_eq($sformatf("step_mono%0d", n), 32'($signed(y) >= $signed(yprev)), 32'd1);
      yprev = y;
    end
    check_eq("step_overrun", 32'(overrun), 32'd0);

    // Extreme coefficients and input: saturation or wrap
    do_reset();
    ovr_en = 1'b1; ovr_val = BIG;
    run_sample(BIG, y, lat);
    ref_sample(BIG, 1'b1, ye);
    check_eq("sat_model", 32'(y), 32'(ye));
`ifdef IIR_SAT_EN
    check_eq("sat_y", 32'(y), 32'h0FFFFFF);
`else
    check_eq("wrap_y", 32'(y), 32'h1FFFFC0);
`endif
    ovr_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
